pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central hazard and sequencing controller for the five-stage RISC-V pipeline. It watches the decode/execute boundary and the execute stage's branch-resolution outputs, then drives stall, flush and PC-redirect controls to fetch, decode and execute. Three situations are sequenced:
- load-use hazards: one bubble;
- multi-cycle execute operations: a fixed-latency hold;
- branch mispredicts: redirect plus bubble injection.

## Interface
Parameters:
- MULTI_LATENCY, 4: cycles a multi-cycle op occupies execute (legal range 2–15).
- FLUSH_CYCLES, 2: bubble cycles injected after a redirect (legal range 1–3).

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- dec_rs1, dec_rs2  in  5 each  source registers of the instruction in decode.
- dec_uses_rs2  in  1  decode instruction reads rs2.
- dec_multi  in  1  decode instruction is a multi-cycle op (MUL/DIV class).
- dec_valid  in  1  decode slot holds a real instruction (not WB_HICCUP).
- ex_rd  in  5  destination register of the instruction in execute.
- ex_is_load  in  1  execute instruction has a nonzero read status.
- mispredict  in  1  branch resolved against its prediction.
- new_pc  in  32  correct target, valid with mispredict.
- stall_fetch, stall_decode  out  1 each  hold the fetch/decode registers.
- bubble_execute  out  1  force the execute input write-back type to WB_HICCUP.
- flush_decode  out  1  replace the decode slot with WB_HICCUP.
- redirect  out  1  load redirect_pc into the PC.
- redirect_pc  out  32  registered copy of new_pc.
- busy  out  1  controller is not in RUN.

## Operation
States: RUN, LOAD_STALL, MULTI_WAIT, FLUSH.

Definitions:
- load_use_hit = dec_valid & ex_is_load & ex_rd≠0 & (ex_rd==dec_rs1 | (dec_uses_rs2 & ex_rd==dec_rs2)).
- x0 never causes a hazard.

RUN transitions, in priority order:
- mispredict → FLUSH. Latch new_pc and set cnt=FLUSH_CYCLES−1.
- load_use_hit → LOAD_STALL.
- dec_valid & dec_multi → MULTI_WAIT. Set cnt=MULTI_LATENCY−1.
- otherwise stay in RUN.

LOAD_STALL:
- Always returns to RUN after exactly one cycle.
- A mispredict in this cycle goes to FLUSH instead.

MULTI_WAIT:
- cnt decrements each cycle. On cnt==0, go to RUN.
- A mispredict seen here sets pend_mp and latches new_pc. The last one wins if repeated.
- On exit with pend_mp set, go to FLUSH instead of RUN and clear pend_mp.

FLUSH:
- cnt decrements each cycle. On cnt==0, go to RUN.
- A new mispredict restarts FLUSH: re-latch new_pc, cnt=FLUSH_CYCLES−1, pulse redirect again.

Outputs:
- stall_fetch = stall_decode = (RUN & load_use_hit) | LOAD_STALL | MULTI_WAIT. Combinational.
- bubble_execute = (RUN & load_use_hit) | LOAD_STALL. Combinational. The stalled consumer is not re-issued into execute twice.
- flush_decode = registered. High in every FLUSH cycle.
- redirect = registered one-cycle pulse, on the first FLUSH cycle only (and on each restart).
- busy = state≠RUN. Registered.

Counter: 4 bits, saturates at 0, never wraps.

## Timing
- Reset (reset_n low, asynchronous): state=RUN, cnt=0, pend_mp=0, redirect_pc=0. Every output is 0 immediately, with no clock required.
- Reset deassertion takes effect at the next posedge.
- Load-use: stall asserts in the same cycle as detection (cycle N) and stays high through N+1. Decode holds for exactly 1 extra cycle.
- Multi-cycle op: stall is high for exactly MULTI_LATENCY cycles, starting the cycle after the op is accepted.
- Mispredict at posedge N: redirect=1 and redirect_pc valid in cycle N+1. flush_decode is high for cycles N+1 … N+FLUSH_CYCLES.
- Mispredict during MULTI_WAIT: redirect appears the cycle after the final stall cycle.
- Reset mid-FLUSH or mid-MULTI_WAIT aborts immediately. Any pending redirect is discarded.

## Structure
- Add to format.vh:
  - state encodings PC_RUN/PC_LOAD_STALL/PC_MULTI_WAIT/PC_FLUSH (2 bits);
  - the FLUSH_CYCLES and MULTI_LATENCY defaults.
- WB_HICCUP continues to come from format.vh.
- One sub-module, hazard_detect: the combinational load_use_hit compare. It is reused later by the forwarding unit.
- The FSM, counter and pending flag stay in pipeline_controller.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, dec_rs1=5, dec_valid=1 → stall_decode=1 and bubble_execute=1 for exactly 2 cycles. Repeat with ex_rd=0 → no stall.
- Multi-cycle: dec_multi=1 with defaults → stall high for exactly 4 cycles, busy deasserts on cycle 5, no bubble_execute.
- Mispredict in RUN: new_pc=0x00000100 → next cycle redirect=1 and redirect_pc=0x00000100. flush_decode high 2 cycles, then RUN.
- Mispredict during MULTI_WAIT, cycle 2: new_pc=0x200 → stall completes all 4 cycles, then redirect with 0x200, then 2 flush cycles.
- Back-to-back mispredicts in FLUSH: 0x100 then 0x300 → second redirect pulse with 0x300, flush window restarts.
- Async reset mid-MULTI_WAIT with pend_mp set → all outputs 0 before the next clock edge. No redirect after release.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: state encodings and default timing for the pipeline hazard controller.
package pipeline_controller_pkg;
    typedef enum logic [1:0] {
        PC_RUN        = 2'd0,
        PC_LOAD_STALL = 2'd1,
        PC_MULTI_WAIT = 2'd2,
        PC_FLUSH      = 2'd3
    } pc_state_e;
    localparam int unsigned PC_FLUSH_CYCLES  = 2;
    localparam int unsigned PC_MULTI_LATENCY = 4;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between decode sources and the execute load target.
module hazard_detect (
    input  logic       dec_valid,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       load_use_hit
);
    assign load_use_hit = dec_valid & ex_is_load & (ex_rd != 5'd0) &
                          ((ex_rd == dec_rs1) | (dec_uses_rs2 & (ex_rd == dec_rs2)));
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: sequences load-use bubbles, multi-cycle execute holds and mispredict redirects/flushes.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int unsigned MULTI_LATENCY = PC_MULTI_LATENCY,
    parameter int unsigned FLUSH_CYCLES  = PC_FLUSH_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_uses_rs2,
    input  logic        dec_multi,
    input  logic        dec_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        mispredict,
    input  logic [31:0] new_pc,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        bubble_execute,
    output logic        flush_decode,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    localparam logic [3:0] MULTI_INIT = 4'(MULTI_LATENCY - 1);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    pc_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_dec;
    logic        pend_q, pend_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d, flush_q, busy_q, load_use_hit, hold;

    hazard_detect u_hazard_detect (
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_uses_rs2 (dec_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .load_use_hit (load_use_hit)
    );

    assign cnt_dec = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_dec;
        pend_d     = pend_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        case (state_q)
            PC_RUN: begin
                if (mispredict) begin
                    state_d    = PC_FLUSH;
                    pc_d       = new_pc;
                    cnt_d      = FLUSH_INIT;
                    redirect_d = 1'b1;
                end else if (load_use_hit) begin
                    state_d = PC_LOAD_STALL;
                end else if (dec_valid & dec_multi) begin
                    state_d = PC_MULTI_WAIT;
                    cnt_d   = MULTI_INIT;
                end
            end
            PC_LOAD_STALL: begin
                state_d = mispredict ? PC_FLUSH : PC_RUN;
                if (mispredict) begin
                    pc_d       = new_pc;
                    cnt_d      = FLUSH_INIT;
                    redirect_d = 1'b1;
                end
            end
            PC_MULTI_WAIT: begin
                // A mispredict is parked until the multi-cycle op drains, latest target wins.
                if (mispredict) begin
                    pend_d = 1'b1;
                    pc_d   = new_pc;
                end
                if (cnt_q == 4'd0) begin
                    state_d = (pend_q | mispredict) ? PC_FLUSH : PC_RUN;
                    if (pend_q | mispredict) begin
                        pend_d     = 1'b0;
                        cnt_d      = FLUSH_INIT;
                        redirect_d = 1'b1;
                    end
                end
            end
            PC_FLUSH: begin
                if (mispredict) begin
                    pc_d       = new_pc;
                    cnt_d      = FLUSH_INIT;
                    redirect_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = PC_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PC_RUN;
            cnt_q      <= 4'd0;
            pend_q     <= 1'b0;
            pc_q       <= 32'd0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            flush_q    <= state_d == PC_FLUSH;
            busy_q     <= state_d != PC_RUN;
        end
    end

    // Gated by reset_n so the combinational stalls also drop to 0 without a clock.
    assign hold           = reset_n & ((state_q == PC_RUN) & load_use_hit | (state_q == PC_LOAD_STALL));
    assign stall_fetch    = hold | (reset_n & (state_q == PC_MULTI_WAIT));
    assign stall_decode   = stall_fetch;
    assign bubble_execute = hold;
    assign flush_decode   = flush_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = pc_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: scoreboard bench; driver queues expected outputs per cycle, monitor checks on negedge.
module tb_pipeline_controller;
    typedef struct packed {
        logic        valid, multi, ld;
        logic [4:0]  rd, rs1, rs2;
        logic        uses2, mp;
        logic [31:0] npc;
    } in_t;
    typedef struct packed {
        logic        stall, bubble, flush, redir, busy;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, ex_rd = '0;
    logic        dec_uses_rs2 = 1'b0, dec_multi = 1'b0, dec_valid = 1'b0, ex_is_load = 1'b0, mispredict = 1'b0;
    logic [31:0] new_pc = '0;
    logic        stall_fetch, stall_decode, bubble_execute, flush_decode, redirect, busy;
    logic [31:0] redirect_pc;

    exp_t sb[$];
    int   ids[$];
    int   checks = 0, errors = 0, n = 0;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .reset_n(reset_n), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_uses_rs2(dec_uses_rs2),
        .dec_multi(dec_multi), .dec_valid(dec_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .mispredict(mispredict), .new_pc(new_pc), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .bubble_execute(bubble_execute), .flush_decode(flush_decode), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    function automatic in_t I(logic valid, logic multi, logic ld, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic uses2, logic mp, logic [31:0] npc);
        return '{valid, multi, ld, rd, rs1, rs2, uses2, mp, npc};
    endfunction

    function automatic exp_t E(logic s, logic b, logic f, logic r, logic y, logic [31:0] pc);
        return '{s, b, f, r, y, pc};
    endfunction

    function automatic logic [37:0] outs();
        return {stall_fetch, stall_decode, bubble_execute, flush_decode, redirect, busy, redirect_pc};
    endfunction

    task automatic chk(input string name, input logic [37:0] got, input logic [37:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got sf,sd,bub,fl,rdr,busy,pc=%h want %h", name, got, want);
        end
    endtask

    task automatic apply(input in_t i);
        dec_valid = i.valid; dec_multi = i.multi; ex_is_load = i.ld; ex_rd = i.rd;
        dec_rs1 = i.rs1; dec_rs2 = i.rs2; dec_uses_rs2 = i.uses2; mispredict = i.mp; new_pc = i.npc;
    endtask

    task automatic cyc(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        apply(i);
        sb.push_back(e);
        ids.push_back(n);
        n++;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   id;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            id = ids.pop_front();
            chk($sformatf("cyc%0d", id), outs(), {e.stall, e.stall, e.bubble, e.flush, e.redir, e.busy, e.pc});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        in_t idle;
        idle = '0;
        apply(I(1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 32'd0));
        #2 chk("reset_async", outs(), 38'd0);
        repeat (2) @(posedge clk);
        #1 chk("reset_held", outs(), 38'd0);
        apply(idle);
        @(negedge clk) reset_n = 1'b1;
        // load-use on rs1: two stall/bubble cycles
        cyc(I(1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0), E(1, 1, 0, 0, 0, 32'h0));
        cyc(idle,                                   E(1, 1, 0, 0, 1, 32'h0));
        cyc(idle,                                   E(0, 0, 0, 0, 0, 32'h0));
        // x0 never hazards, rs2 only when used, invalid decode never hazards
        cyc(I(1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0), E(0, 0, 0, 0, 0, 32'h0));
        cyc(I(1, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0), E(0, 0, 0, 0, 0, 32'h0));
        cyc(I(0, 0, 1, 5'd7, 5'd7, 5'd7, 1, 0, 0), E(0, 0, 0, 0, 0, 32'h0));
        cyc(I(1, 0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0), E(1, 1, 0, 0, 0, 32'h0));
        cyc(idle,                                   E(1, 1, 0, 0, 1, 32'h0));
        cyc(idle,                                   E(0, 0, 0, 0, 0, 32'h0));
        // multi-cycle op: four stall cycles, no bubble
        cyc(I(1, 1, 0, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 32'h0));
        repeat (4) cyc(idle,              E(1, 0, 0, 0, 1, 32'h0));
        cyc(idle,                         E(0, 0, 0, 0, 0, 32'h0));
        // mispredict in RUN
        cyc(I(0, 0, 0, 0, 0, 0, 0, 1, 32'h100), E(0, 0, 0, 0, 0, 32'h0));
        cyc(idle,                               E(0, 0, 1, 1, 1, 32'h100));
        cyc(idle,                               E(0, 0, 1, 0, 1, 32'h100));
        cyc(idle,                               E(0, 0, 0, 0, 0, 32'h100));
        // mispredict during MULTI_WAIT cycle 2 waits for the hold to finish
        cyc(I(1, 1, 0, 0, 0, 0, 0, 0, 0),       E(0, 0, 0, 0, 0, 32'h100));
        cyc(idle,                               E(1, 0, 0, 0, 1, 32'h100));
        cyc(I(0, 0, 0, 0, 0, 0, 0, 1, 32'h200), E(1, 0, 0, 0, 1, 32'h100));
        cyc(idle,                               E(1, 0, 0, 0, 1, 32'h200));
        cyc(idle,                               E(1, 0, 0, 0, 1, 32'h200));
        cyc(idle,                               E(0, 0, 1, 1, 1, 32'h200));
        cyc(idle,                               E(0, 0, 1, 0, 1, 32'h200));
        cyc(idle,                               E(0, 0, 0, 0, 0, 32'h200));
        // back-to-back mispredicts restart the flush window
        cyc(I(0, 0, 0, 0, 0, 0, 0, 1, 32'h100), E(0, 0, 0, 0, 0, 32'h200));
        cyc(I(0, 0, 0, 0, 0, 0, 0, 1, 32'h300), E(0, 0, 1, 1, 1, 32'h100));
        cyc(idle,                               E(0, 0, 1, 1, 1, 32'h300));
        cyc(idle,                               E(0, 0, 1, 0, 1, 32'h300));
        cyc(idle,                               E(0, 0, 0, 0, 0, 32'h300));
        // mispredict during LOAD_STALL goes straight to FLUSH
        cyc(I(1, 0, 1, 5'd9, 5'd9, 0, 0, 0, 0), E(1, 1, 0, 0, 0, 32'h300));
        cyc(I(0, 0, 0, 0, 0, 0, 0, 1, 32'h400), E(1, 1, 0, 0, 1, 32'h300));
        cyc(idle,                               E(0, 0, 1, 1, 1, 32'h400));
        cyc(idle,                               E(0, 0, 1, 0, 1, 32'h400));
        cyc(idle,                               E(0, 0, 0, 0, 0, 32'h400));
        // reset mid-MULTI_WAIT with a pending mispredict
        cyc(I(1, 1, 0, 0, 0, 0, 0, 0, 0),       E(0, 0, 0, 0, 0, 32'h400));
        cyc(I(0, 0, 0, 0, 0, 0, 0, 1, 32'h500), E(1, 0, 0, 0, 1, 32'h400));
        cyc(idle,                               E(1, 0, 0, 0, 1, 32'h500));
        drain();
        #1 reset_n = 1'b0;
        #1 chk("reset_mid_multi", outs(), 38'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) cyc(idle, E(0, 0, 0, 0, 0, 32'h0));
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
